reg_file_mp: RTL and testbench

- Parametrised multi-read-port general-purpose register file for the pipelined ARM datapath. Successor to the fixed 2-read/1-write, 32x64 register memory.
- Adds configurable width, depth and read-port count, a pending-write scoreboard for hazard detection, write-to-read bypass, and a sequenced bulk-clear engine.
- Sits between decode (reads, allocation) and writeback (writes).

---
 rtl/reg_file_pkg.sv | 25 ++
 rtl/reg_file_scoreboard.sv | 57 +++++
 rtl/reg_file_mp.sv | 162 ++++++++++++++++
 tb/tb_reg_file_mp.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Purpose  : Shared constants and clear-FSM state encoding for the
//            multi-read-port register file.
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  // Default geometry of the architectural register file
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned DEPTH_DEF  = 32;

  // Hard-wired zero register
  localparam int unsigned ZERO_REG   = 0;

  // Bulk-clear sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scoreboard
// Purpose  : Pending-write bit per register. Set by decode allocation,
//            cleared by writeback, flushed by the bulk clear. Provides one
//            combinational lookup per read port.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_pending
);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Next pending vector: flush dominates, and a set applied after the clear
  // lets a fresh allocation win over a same-cycle writeback.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (clr_en) pending_d[clr_addr] = 1'b0;
      if (set_en) pending_d[set_addr] = 1'b1;
    end
    pending_d[ZERO_REG] = 1'b0;
  end

  // Pending vector storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
      assign rd_pending[gi] = pending_q[rd_addr[gi*ADDR_W +: ADDR_W]];
    end
  endgenerate

endmodule : reg_file_scoreboard
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Parametrised multi-read-port register file with pending-write
//            scoreboard, optional write-to-read bypass and a sequenced
//            bulk-clear engine. Register 0 is hard-wired to zero.
// Options  : REGFILE_BYPASS_EN - forward same-cycle writeback data/pending
//            status to matching read ports.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              idle;
  logic              wr_ok;
  logic              alloc_ok;
  logic              flush;
  logic [NUM_RD-1:0] sb_pending;

  // Writes and allocations are only honoured while no clear is running
  assign idle     = (state_q == ST_IDLE);
  assign wr_ok    = wr_en    && (wr_addr    != ZERO_ADDR) && idle;
  assign alloc_ok = alloc_en && (alloc_addr != ZERO_ADDR) && idle;
  assign flush    = idle && clr_req;

  // Clear sequencer next state: sweep one register per cycle, stop at the
  // last index without wrapping, then pulse done for a single cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_busy_d = 1'b0;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d    = ST_SWEEP;
          idx_d      = '0;
          clr_busy_d = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (idx_q == LAST_ADDR) begin
          state_d    = ST_DONE;
          clr_done_d = 1'b1;
        end else begin
          idx_d      = idx_q + ADDR_W'(1);
          clr_busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear sequencer state, sweep index and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

  // Array next state: writeback in idle, one zeroed entry per sweep cycle
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
    if (state_q == ST_SWEEP) mem_d[idx_q] = '0;
  end

  // Register array storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  reg_file_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (alloc_ok),
    .set_addr   (alloc_addr),
    .clr_en     (wr_ok),
    .clr_addr   (wr_addr),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_pending (sb_pending)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] raddr;
      logic [DATA_W-1:0] arr_data;

      assign raddr    = rd_addr[gi*ADDR_W +: ADDR_W];
      assign arr_data = (raddr == ZERO_ADDR) ? '0 : mem_q[raddr];

`ifdef REGFILE_BYPASS_EN
      logic byp;
      // Forward the in-flight writeback; a same-cycle allocation to the
      // same register still marks it pending.
      assign byp = wr_ok && (raddr == wr_addr);
      assign rd_data[gi*DATA_W +: DATA_W] = byp ? wr_data : arr_data;
      assign rd_pending[gi] = byp ? (alloc_ok && (alloc_addr == raddr))
                                  : sb_pending[gi];
`else
      assign rd_data[gi*DATA_W +: DATA_W] = arr_data;
      assign rd_pending[gi]               = sb_pending[gi];
`endif
    end
  endgenerate

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Directed self-checking bench for reg_file_mp (default geometry:
//            64-bit x 32 registers, 2 read ports). Works with or without
//            REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;

  int checks = 0;
  int errors = 0;

  reg_file_mp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance exactly one rising edge; all driving and sampling is at negedge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic look(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic alloc_reg(input logic [ADDR_W-1:0] a);
    alloc_en = 1'b1; alloc_addr = a;
    tick();
    alloc_en = 1'b0;
  endtask

  // Start a clear and count busy/done cycles over a bounded window. With
  // mid set, clr_req is held into the sweep and a write/alloc is attempted.
  task automatic run_sweep(input bit mid, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    clr_req = 1'b1;
    tick();
    if (!mid) clr_req = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (clr_busy) busy_n++;
      if (clr_done) done_n++;
      if (c == 3) clr_req = 1'b0;
      if (mid && c == 6) begin
        // registers 0..5 cleared so far, 31 untouched
        look(ADDR_W'(1), ADDR_W'(31));
        check("mid_sweep_r1", 64'(rd_data[63:0]), 64'h0);
        check("mid_sweep_r31", 64'(rd_data[127:64]), 64'h101F);
        wr_en = 1'b1; wr_addr = ADDR_W'(2); wr_data = 64'hBAD;
        alloc_en = 1'b1; alloc_addr = ADDR_W'(4);
      end
      if (c == 7) begin
        wr_en = 1'b0;
        alloc_en = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n;
    int done_n;

    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; clr_req = 1'b0;

    // Reset state
    look(ADDR_W'(1), ADDR_W'(5));
    check("rst_busy", 64'(clr_busy), 64'h0);
    check("rst_done", 64'(clr_done), 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    look(ADDR_W'(1), ADDR_W'(5));
    check("rst_data0", 64'(rd_data[63:0]), 64'h0);
    check("rst_data1", 64'(rd_data[127:64]), 64'h0);
    check("rst_pend", 64'(rd_pending), 64'h0);

    // Register 0 ignores writes and allocations
    write_reg(ADDR_W'(0), 64'hDEAD);
    alloc_reg(ADDR_W'(0));
    look(ADDR_W'(0), ADDR_W'(0));
    check("r0_data", 64'(rd_data[63:0]), 64'h0);
    check("r0_pend", 64'(rd_pending), 64'h0);

    // Allocation then writeback clears the pending bit
    alloc_reg(ADDR_W'(7));
    look(ADDR_W'(7), ADDR_W'(7));
    check("alloc7_pend", 64'(rd_pending), 64'h3);
    write_reg(ADDR_W'(7), 64'h1234);
    look(ADDR_W'(7), ADDR_W'(7));
    check("wr7_pend", 64'(rd_pending), 64'h0);
    check("wr7_data0", 64'(rd_data[63:0]), 64'h1234);
    check("wr7_data1", 64'(rd_data[127:64]), 64'h1234);

    // Same-cycle alloc and write: allocation wins
    alloc_en = 1'b1; alloc_addr = ADDR_W'(9);
    wr_en = 1'b1; wr_addr = ADDR_W'(9); wr_data = 64'h55;
    look(ADDR_W'(9), ADDR_W'(9));
    check("aw9_pend_same", 64'(rd_pending[0]), BYP ? 64'h1 : 64'h0);
    tick();
    alloc_en = 1'b0; wr_en = 1'b0;
    #1;
    check("aw9_pend", 64'(rd_pending[0]), 64'h1);
    check("aw9_data", 64'(rd_data[63:0]), 64'h55);

    // Bypass / write latency
    write_reg(ADDR_W'(3), 64'h1111);
    wr_en = 1'b1; wr_addr = ADDR_W'(3); wr_data = 64'hABCD;
    look(ADDR_W'(3), ADDR_W'(7));
    check("byp_same", 64'(rd_data[63:0]), BYP ? 64'hABCD : 64'h1111);
    check("byp_other", 64'(rd_data[127:64]), 64'h1234);
    tick();
    wr_en = 1'b0;
    #1;
    check("byp_next", 64'(rd_data[63:0]), 64'hABCD);

    // Fill 1..31 and sweep
    for (int a = 1; a < DEPTH; a++) write_reg(ADDR_W'(a), 64'h1000 + 64'(a));
    alloc_reg(ADDR_W'(12));
    look(ADDR_W'(17), ADDR_W'(31));
    check("fill_r17", 64'(rd_data[63:0]), 64'h1011);
    check("fill_r31", 64'(rd_data[127:64]), 64'h101F);
    run_sweep(1'b1, busy_n, done_n);
    check("sweep1_busy", 64'(busy_n), 64'd32);
    check("sweep1_done", 64'(done_n), 64'd1);
    for (int a = 0; a < DEPTH; a++) begin
      look(ADDR_W'(a), ADDR_W'(a));
      check($sformatf("clr_r%0d", a), 64'(rd_data[63:0]), 64'h0);
      check($sformatf("clr_p%0d", a), 64'(rd_pending[0]), 64'h0);
    end

    // Reset in the middle of a sweep
    write_reg(ADDR_W'(31), 64'h77);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    look(ADDR_W'(31), ADDR_W'(31));
    check("pre_abort_r31", 64'(rd_data[63:0]), 64'h77);
    check("pre_abort_busy", 64'(clr_busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(clr_busy), 64'h0);
    check("abort_done", 64'(clr_done), 64'h0);
    check("abort_r31", 64'(rd_data[63:0]), 64'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    #1;
    check("post_rst_busy", 64'(clr_busy), 64'h0);

    // Restarted sweep runs the full length
    write_reg(ADDR_W'(31), 64'h88);
    run_sweep(1'b0, busy_n, done_n);
    check("sweep2_busy", 64'(busy_n), 64'd32);
    check("sweep2_done", 64'(done_n), 64'd1);
    look(ADDR_W'(31), ADDR_W'(3));
    check("sweep2_r31", 64'(rd_data[63:0]), 64'h0);

    // Normal writes resume after the clear
    write_reg(ADDR_W'(5), 64'hCAFE);
    look(ADDR_W'(5), ADDR_W'(5));
    check("post_clr_wr", 64'(rd_data[127:64]), 64'hCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_mp
`default_nettype wire
